// File: rtl/eth_transmitter_if.sv
// CPU memory-bus bundle for the frame transmitter: one-clock strobes,
// read data returned the clock after cpu_re.
interface eth_transmitter_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;

  modport master (
    output cpu_a, cpu_wdata, cpu_we, cpu_re,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_a, cpu_wdata, cpu_we, cpu_re,
    output cpu_rdata
  );
endinterface

// File: rtl/eth_transmitter.sv
// CPU-loaded frame buffer shifted out LSB-first on a three-wire serial link
// (sck/mosi/n_ss) towards the Ethernet bridge.
module eth_transmitter #(
  parameter int          BUF_AW   = 11,
  parameter logic [15:0] BUF_BASE = 16'hE800,
  parameter logic [15:0] REG_BASE = 16'hFB08,
  parameter int          SCK_DIV  = 2,
  parameter int          GUARD    = 4
) (
  input  logic             clk,
  input  logic             rst,
  eth_transmitter_if.slave bus,
  output logic             tx_sck,
  output logic             tx_mosi,
  output logic             n_tx_ss,
  output logic             tx_busy,
  output logic             tx_done_irq
);

  localparam int BUF_BYTES = 1 << BUF_AW;
  localparam int IDX_W     = BUF_AW + 1;
  localparam int CNT_MAX   = (SCK_DIV > GUARD) ? SCK_DIV : GUARD;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_BIT_LO, S_BIT_HI, S_TAIL
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [15:0]      len_q;
  logic             done_q, err_q, busy_q;
  logic             sck_q, mosi_q, nss_q;

  logic [7:0]        mem [BUF_BYTES];
  logic [7:0]        mem_rd_q;
  logic [BUF_AW-1:0] rd_addr;
  logic              rd_buf_q;
  logic [7:0]        rd_reg_q;

  logic       buf_hit, cr_hit, len_lo_hit, len_hi_hit;
  logic       cr_wr, start_req, len_ok;
  logic       done_d, err_d;
  logic [7:0] reg_mux;

  assign buf_hit    = (bus.cpu_a[15:BUF_AW] == BUF_BASE[15:BUF_AW]);
  assign cr_hit     = (bus.cpu_a == REG_BASE);
  assign len_lo_hit = (bus.cpu_a == REG_BASE + 16'd2);
  assign len_hi_hit = (bus.cpu_a == REG_BASE + 16'd3);

  assign cr_wr     = bus.cpu_we && cr_hit;
  assign start_req = cr_wr && bus.cpu_wdata[0] && !busy_q;
  assign len_ok    = (len_q != 16'd0) && (len_q <= 16'(BUF_BYTES));

  // W1C clears land first, so a combined clear+START still reports a bad length.
  assign done_d = done_q && !(cr_wr && bus.cpu_wdata[2-1]);
  assign err_d  = (err_q && !(cr_wr && bus.cpu_wdata[2])) || (start_req && !len_ok);

  always_comb begin
    reg_mux = 8'h00;
    if (cr_hit)          reg_mux = {5'b0, err_q, done_q, busy_q};
    else if (len_lo_hit) reg_mux = len_q[7:0];
    else if (len_hi_hit) reg_mux = len_q[15:8];
  end

  // The single RAM read port belongs to the CPU when idle and to the shifter when busy.
  assign rd_addr = busy_q ? idx_q[BUF_AW-1:0] : bus.cpu_a[BUF_AW-1:0];

  always_ff @(posedge clk) begin
    if (bus.cpu_we && buf_hit && !busy_q)
      mem[bus.cpu_a[BUF_AW-1:0]] <= bus.cpu_wdata;
    mem_rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_buf_q <= 1'b0;
      rd_reg_q <= 8'h00;
    end else begin
      rd_buf_q <= bus.cpu_re && buf_hit && !busy_q;
      rd_reg_q <= bus.cpu_re ? reg_mux : 8'h00;
    end
  end

  assign bus.cpu_rdata = rd_buf_q ? mem_rd_q : rd_reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      len_q   <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      nss_q   <= 1'b1;
    end else begin
      if (bus.cpu_we && !busy_q) begin
        if (len_lo_hit) len_q[7:0]  <= bus.cpu_wdata;
        if (len_hi_hit) len_q[15:8] <= bus.cpu_wdata;
      end
      done_q <= done_d;
      err_q  <= err_d;

      case (state_q)
        S_IDLE: begin
          if (start_req && len_ok) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
            nss_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_SETUP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FETCH: begin
          shift_q <= mem_rd_q;
          mosi_q  <= mem_rd_q[0];
          bit_q   <= 3'd0;
          state_q <= S_BIT_LO;
        end
        S_BIT_LO: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            sck_q   <= 1'b1;
            state_q <= S_BIT_HI;
            // Advance early so the RAM has the next byte ready by FETCH.
            if (bit_q == 3'd7) idx_q <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            if (bit_q == 3'd7) begin
              state_q <= (16'(idx_q) < len_q) ? S_FETCH : S_TAIL;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              mosi_q  <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
              state_q <= S_BIT_LO;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_TAIL: begin
          if (cnt_q == GUARD_LAST) begin
            cnt_q   <= '0;
            nss_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_sck      = sck_q;
  assign tx_mosi     = mosi_q;
  assign n_tx_ss     = nss_q;
  assign tx_busy     = busy_q;
  assign tx_done_irq = done_q;

endmodule

// File: tb/tb_eth_transmitter.sv
// Directed bench for eth_transmitter: a transaction-level model tracks the
// registers, buffer and frame window; a per-cycle process checks the pins.
module tb_eth_transmitter;
  localparam int          BUF_AW    = 11;
  localparam int          BUF_BYTES = 1 << BUF_AW;
  localparam logic [15:0] BUFB      = 16'hE800;
  localparam logic [15:0] REGB      = 16'hFB08;
  localparam int          SCK_DIV   = 2;
  localparam int          GUARD     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_sck, tx_mosi, n_tx_ss, tx_busy, tx_done_irq;

  eth_transmitter_if bus_if ();

  eth_transmitter #(
    .BUF_AW(BUF_AW), .BUF_BASE(BUFB), .REG_BASE(REGB),
    .SCK_DIV(SCK_DIV), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .tx_sck(tx_sck), .tx_mosi(tx_mosi), .n_tx_ss(n_tx_ss),
    .tx_busy(tx_busy), .tx_done_irq(tx_done_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [7:0]  mem_m [BUF_BYTES];
  logic [15:0] len_m;
  bit          done_m, err_m, busy_seen, cmp_en;
  int          left;

  // Serial capture state
  logic [7:0] rx_q [$];
  logic [7:0] sh;
  int         bitn, sck_edges, low_cnt, nss_falls;
  logic       nss_prev;

  logic [7:0] tv [10] = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'hAA, 8'h55, 8'h73, 8'h87};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    if (a == REGB) begin
      if (d[1]) done_m = 1'b0;
      if (d[2]) err_m  = 1'b0;
      if (d[0] && !busy_seen) begin
        if (len_m == 16'd0 || int'(len_m) > BUF_BYTES) err_m = 1'b1;
        else left = SCK_DIV + int'(len_m) * (1 + 16 * SCK_DIV) + GUARD;
      end
    end else if (!busy_seen) begin
      if (a == REGB + 16'd2) len_m[7:0]  = d;
      if (a == REGB + 16'd3) len_m[15:8] = d;
      if (int'(a) >= int'(BUFB) && int'(a) < int'(BUFB) + BUF_BYTES) mem_m[a - BUFB] = d;
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    if (a == REGB) return {5'b0, err_m, done_m, busy_seen};
    if (a == REGB + 16'd2) return len_m[7:0];
    if (a == REGB + 16'd3) return len_m[15:8];
    if (int'(a) >= int'(BUFB) && int'(a) < int'(BUFB) + BUF_BYTES)
      return busy_seen ? 8'h00 : mem_m[a - BUFB];
    return 8'h00;
  endfunction

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.cpu_a = a; bus_if.cpu_wdata = d; bus_if.cpu_we = 1'b1;
    @(posedge clk); #1;
    bus_if.cpu_we = 1'b0;
    model_wr(a, d);
  endtask

  // Read with both a literal expectation and the model's view of the same location.
  task automatic rd_expect(input string name, input logic [15:0] a, input logic [7:0] lit);
    logic [7:0] d, m;
    @(posedge clk); #1;
    bus_if.cpu_a = a; bus_if.cpu_re = 1'b1;
    @(posedge clk); #1;
    bus_if.cpu_re = 1'b0;
    d = bus_if.cpu_rdata;
    m = model_rd(a);
    $display("[TB] rd %-10s @%h = %h (lit %h, model %h)", name, a, d, lit, m);
    check(name, d, lit);
    check({name, "_model"}, d, m);
  endtask

  task automatic clear_capture();
    rx_q.delete();
    bitn = 0; sck_edges = 0; low_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((left != 0 || n_tx_ss !== 1'b1) && n < budget) begin
      @(posedge clk); n++;
    end
    check({name, "_timeout"}, n < budget, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input int len, input bit use_tv);
    check({name, "_nbytes"}, rx_q.size(), len);
    check({name, "_edges"}, sck_edges, 8 * len);
    for (int i = 0; i < len && i < rx_q.size(); i++) begin
      check({name, "_byte"}, rx_q[i], mem_m[i]);
      if (use_tv && i < 10) check({name, "_lit"}, rx_q[i], tv[i]);
    end
    $display("[TB] frame %s: %0d bytes, %0d sck edges, %0d clk with n_ss low",
             name, rx_q.size(), sck_edges, low_cnt);
  endtask

  task automatic set_len(input logic [15:0] l);
    cpu_wr(REGB + 16'd2, l[7:0]);
    cpu_wr(REGB + 16'd3, l[15:8]);
  endtask

  initial begin
    bus_if.cpu_a = 16'h0; bus_if.cpu_wdata = 8'h0;
    bus_if.cpu_we = 1'b0; bus_if.cpu_re = 1'b0;
    left = 0; done_m = 0; err_m = 0; len_m = 0; busy_seen = 0; cmp_en = 0;
    nss_falls = 0; nss_prev = 1'b1; sh = 8'h00;
    clear_capture();
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          check("nss", n_tx_ss, left == 0);
          check("busy", tx_busy, left != 0);
          check("done_irq", tx_done_irq, done_m);
          if (left == 0) begin
            check("sck_idle", tx_sck, 0);
            check("mosi_idle", tx_mosi, 0);
          end
        end
        busy_seen = (left != 0);
        if (left > 0) begin
          left--;
          if (left == 0) done_m = 1'b1;
        end
        if (n_tx_ss === 1'b0) low_cnt++;
        if (nss_prev === 1'b1 && n_tx_ss === 1'b0) nss_falls++;
        nss_prev = n_tx_ss;
      end
      forever begin
        @(posedge tx_sck);
        sh = {tx_mosi, sh[7:1]};
        bitn++; sck_edges++;
        if (bitn == 8) begin
          rx_q.push_back(sh);
          bitn = 0;
        end
      end
      begin
        int n, falls0;
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1;
        check("rst_nss", n_tx_ss, 1);
        check("rst_sck", tx_sck, 0);
        check("rst_mosi", tx_mosi, 0);
        rd_expect("rst_cr", REGB, 8'h00);
        rd_expect("rst_lenlo", REGB + 16'd2, 8'h00);
        rd_expect("rst_lenhi", REGB + 16'd3, 8'h00);
        rd_expect("unmapped", REGB + 16'd1, 8'h00);

        // 10-byte frame
        for (int i = 0; i < 10; i++) cpu_wr(BUFB + 16'(i), tv[i]);
        rd_expect("buf0", BUFB, 8'hFE);
        rd_expect("buf9", BUFB + 16'd9, 8'h87);
        set_len(16'd10);
        rd_expect("lenlo10", REGB + 16'd2, 8'h0A);
        clear_capture();
        cpu_wr(REGB, 8'h01);
        wait_idle("f10", 2000);
        check_frame("f10", 10, 1);
        check("f10_nss_low", low_cnt, 336);
        rd_expect("f10_cr", REGB, 8'h02);
        check("f10_irq", tx_done_irq, 1);
        cpu_wr(REGB, 8'h02);
        rd_expect("f10_cr_clr", REGB, 8'h00);

        // Bad lengths
        falls0 = nss_falls;
        set_len(16'd0);
        cpu_wr(REGB, 8'h01);
        rd_expect("len0_cr", REGB, 8'h04);
        repeat (20) @(posedge clk);
        check("len0_nofall", nss_falls, falls0);
        cpu_wr(REGB, 8'h04);
        rd_expect("len0_clr", REGB, 8'h00);
        set_len(16'd2049);
        cpu_wr(REGB, 8'h01);
        rd_expect("len2049_cr", REGB, 8'h04);
        repeat (20) @(posedge clk);
        check("len2049_nofall", nss_falls, falls0);
        cpu_wr(REGB, 8'h04);
        rd_expect("len2049_clr", REGB, 8'h00);

        // Writes while busy are ignored
        set_len(16'd10);
        clear_capture();
        cpu_wr(REGB, 8'h01);
        repeat (30) @(posedge clk);
        cpu_wr(BUFB, 8'hAA);
        cpu_wr(REGB + 16'd2, 8'h01);
        cpu_wr(REGB, 8'h01);
        rd_expect("busy_bufrd", BUFB, 8'h00);
        rd_expect("busy_cr", REGB, 8'h01);
        wait_idle("fbusy", 2000);
        check_frame("fbusy", 10, 1);
        check("fbusy_nss_low", low_cnt, 336);
        rd_expect("fbusy_buf0", BUFB, 8'hFE);
        rd_expect("fbusy_lenlo", REGB + 16'd2, 8'h0A);
        rd_expect("fbusy_cr", REGB, 8'h02);

        // Reset mid-frame
        cpu_wr(REGB, 8'h02);
        clear_capture();
        cpu_wr(REGB, 8'h01);
        n = 0;
        while (sck_edges < 20 && n < 5000) begin
          @(posedge clk); n++;
        end
        check("mid_edges_timeout", n < 5000, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        left = 0; done_m = 0; err_m = 0; len_m = 16'd0;
        check("mid_nss", n_tx_ss, 1);
        check("mid_sck", tx_sck, 0);
        check("mid_mosi", tx_mosi, 0);
        check("mid_busy", tx_busy, 0);
        rst = 1'b0;
        rd_expect("mid_cr", REGB, 8'h00);
        set_len(16'd10);
        clear_capture();
        cpu_wr(REGB, 8'h01);
        wait_idle("fpost", 2000);
        check_frame("fpost", 10, 1);
        rd_expect("fpost_cr", REGB, 8'h02);

        // Full buffer, no wrap
        for (int i = 0; i < BUF_BYTES; i++) cpu_wr(BUFB + 16'(i), 8'(i));
        set_len(16'd2048);
        clear_capture();
        cpu_wr(REGB, 8'h01);
        wait_idle("ffull", 70000);
        check_frame("ffull", BUF_BYTES, 0);
        check("ffull_edges_lit", sck_edges, 16384);
        if (rx_q.size() == BUF_BYTES) begin
          check("ffull_b256", rx_q[256], 8'h00);
          check("ffull_b2047", rx_q[2047], 8'hFF);
        end else begin
          check("ffull_size", rx_q.size(), BUF_BYTES);
        end
        rd_expect("ffull_cr", REGB, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join
  end
endmodule
